// File: rtl/vvctrl_issue_sequencer_pkg.sv
// Shared controller definitions: word geometry, opcodes and issue-FSM states.
package vvctrl_issue_sequencer_pkg;

    localparam int unsigned VVENG_INSTRUCTION_WIDTH = 32;
    localparam int unsigned VVCTRL_OPCODE_WIDTH     = 5;
    localparam int unsigned VVCTRL_WAITCYCLE_WIDTH  = 8;
    localparam int unsigned VVCTRL_DRAIN_CYCLES     = 2;

    typedef logic [VVCTRL_OPCODE_WIDTH-1:0] vvctrl_opcode_t;

    localparam vvctrl_opcode_t VVCTRL_NOP       = 5'd0;
    localparam vvctrl_opcode_t VVCTRL_ADD_XY    = 5'd1;
    localparam vvctrl_opcode_t VVCTRL_SUB_XY    = 5'd2;
    localparam vvctrl_opcode_t VVCTRL_MULT_XY   = 5'd3;
    localparam vvctrl_opcode_t VVCTRL_RELU      = 5'd4;
    localparam vvctrl_opcode_t VVCTRL_ACTLOOKUP = 5'd5;
    localparam vvctrl_opcode_t VVCTRL_WAIT      = 5'd6;

    typedef enum logic [2:0] {
        ISSUE_IDLE,
        ISSUE_RUN,
        ISSUE_WAIT,
        ISSUE_BUBBLE,
        ISSUE_DRAIN,
        ISSUE_DONE
    } issue_state_e;

endpackage

// File: rtl/vvctrl_issue_sequencer_if.sv
// Instruction stream in, issue word out, between producer and issue sequencer.
interface vvctrl_issue_sequencer_if #(
    parameter int unsigned INSTRUCTION_WIDTH = vvctrl_issue_sequencer_pkg::VVENG_INSTRUCTION_WIDTH
);
    logic [INSTRUCTION_WIDTH-1:0] instrIn;
    logic                         instrValid;
    logic                         instrLast;
    logic                         instrReady;
    logic [INSTRUCTION_WIDTH-1:0] issueInstr;
    logic                         issueValid;

    modport master (
        output instrIn, instrValid, instrLast,
        input  instrReady, issueInstr, issueValid
    );

    modport slave (
        input  instrIn, instrValid, instrLast,
        output instrReady, issueInstr, issueValid
    );
endinterface

// File: rtl/vvctrl_instruction_decoder.sv
// Field extraction from an instruction word: opcode in the MSBs, wait count in the LSBs.
module vvctrl_instruction_decoder
    import vvctrl_issue_sequencer_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH = VVENG_INSTRUCTION_WIDTH,
    parameter int unsigned OPCODE_WIDTH      = VVCTRL_OPCODE_WIDTH,
    parameter int unsigned WAITCYCLE_WIDTH   = VVCTRL_WAITCYCLE_WIDTH
) (
    input  logic [INSTRUCTION_WIDTH-1:0] instr_i,
    output logic [OPCODE_WIDTH-1:0]      opcode_c,
    output logic [WAITCYCLE_WIDTH-1:0]   waitcycle_c
);

    logic unused_operand_c;

    assign opcode_c         = instr_i[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
    assign waitcycle_c      = instr_i[WAITCYCLE_WIDTH-1:0];
    // Operand bits between the two fields are consumed downstream, not here.
    assign unused_operand_c = ^instr_i[INSTRUCTION_WIDTH-OPCODE_WIDTH-1:WAITCYCLE_WIDTH];

endmodule

// File: rtl/vvctrl_issue_sequencer.sv
// Issue sequencer: one word per enabled cycle to the signal generator, expanding
// WAITs, bubbling after ACTLOOKUP and draining the generator pipeline at program end.
module vvctrl_issue_sequencer
    import vvctrl_issue_sequencer_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH = VVENG_INSTRUCTION_WIDTH,
    parameter int unsigned OPCODE_WIDTH      = VVCTRL_OPCODE_WIDTH,
    parameter int unsigned WAITCYCLE_WIDTH   = VVCTRL_WAITCYCLE_WIDTH,
    parameter int unsigned DRAIN_CYCLES      = VVCTRL_DRAIN_CYCLES
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     dbg_clk_enable,
    vvctrl_issue_sequencer_if.slave  seq_if,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned DRAIN_CNT_WIDTH = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    issue_state_e                 state_q, state_d;
    logic [WAITCYCLE_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
    logic [DRAIN_CNT_WIDTH-1:0]   drain_cnt_q, drain_cnt_d;
    logic                         last_q, last_d;
    logic                         ready_q, ready_d;
    logic [INSTRUCTION_WIDTH-1:0] issue_instr_q, issue_instr_d;
    logic                         issue_valid_q, issue_valid_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;

    logic [OPCODE_WIDTH-1:0]      opcode_c;
    logic [WAITCYCLE_WIDTH-1:0]   waitcycle_c;
    logic                         accept_c;

    vvctrl_instruction_decoder #(
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
        .OPCODE_WIDTH      (OPCODE_WIDTH),
        .WAITCYCLE_WIDTH   (WAITCYCLE_WIDTH)
    ) u_decoder (
        .instr_i     (seq_if.instrIn),
        .opcode_c    (opcode_c),
        .waitcycle_c (waitcycle_c)
    );

    assign accept_c = ready_q & seq_if.instrValid;

    // Next state; a disabled step holds everything and only forces the issue slot to NOP.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        last_d        = last_q;
        ready_d       = ready_q;
        busy_d        = busy_q;
        done_d        = done_q;
        issue_instr_d = '0;
        issue_valid_d = 1'b0;

        if (dbg_clk_enable) begin
            case (state_q)
                ISSUE_IDLE, ISSUE_RUN: begin
                    if (accept_c) begin
                        last_d  = seq_if.instrLast;
                        state_d = ISSUE_RUN;
                        if (opcode_c == OPCODE_WIDTH'(VVCTRL_WAIT)) begin
                            wait_cnt_d = waitcycle_c;
                            if (waitcycle_c != '0) begin
                                state_d = ISSUE_WAIT;
                            end else if (seq_if.instrLast) begin
                                state_d = ISSUE_DRAIN;
                            end
                        end else begin
                            issue_instr_d = seq_if.instrIn;
                            issue_valid_d = 1'b1;
                            if (opcode_c == OPCODE_WIDTH'(VVCTRL_ACTLOOKUP)) begin
                                state_d = ISSUE_BUBBLE;
                            end else if (seq_if.instrLast) begin
                                state_d = ISSUE_DRAIN;
                            end
                        end
                    end
                end
                ISSUE_WAIT: begin
                    wait_cnt_d = wait_cnt_q - WAITCYCLE_WIDTH'(1);
                    if (wait_cnt_q == WAITCYCLE_WIDTH'(1)) begin
                        state_d = last_q ? ISSUE_DRAIN : ISSUE_RUN;
                    end
                end
                ISSUE_BUBBLE: begin
                    state_d = last_q ? ISSUE_DRAIN : ISSUE_RUN;
                end
                ISSUE_DRAIN: begin
                    if (drain_cnt_q == '0) begin
                        state_d = ISSUE_DONE;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DRAIN_CNT_WIDTH'(1);
                    end
                end
                ISSUE_DONE: begin
                    state_d = ISSUE_IDLE;
                end
                default: begin
                    state_d = ISSUE_IDLE;
                end
            endcase

            if ((state_d == ISSUE_DRAIN) && (state_q != ISSUE_DRAIN)) begin
                drain_cnt_d = DRAIN_CNT_WIDTH'(DRAIN_CYCLES);
            end

            ready_d = (state_d == ISSUE_IDLE) || (state_d == ISSUE_RUN);
            busy_d  = (state_d != ISSUE_IDLE);
            done_d  = (state_d == ISSUE_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ISSUE_IDLE;
            wait_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            last_q        <= 1'b0;
            ready_q       <= 1'b0;
            issue_instr_q <= '0;
            issue_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            last_q        <= last_d;
            ready_q       <= ready_d;
            issue_instr_q <= issue_instr_d;
            issue_valid_q <= issue_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign seq_if.instrReady = ready_q;
    assign seq_if.issueInstr = issue_instr_q;
    assign seq_if.issueValid = issue_valid_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_vvctrl_issue_sequencer.sv
// Randomized bench for the issue sequencer against a transaction-level schedule model.
module tb_vvctrl_issue_sequencer;
    import vvctrl_issue_sequencer_pkg::*;

    localparam int unsigned IW = VVENG_INSTRUCTION_WIDTH;
    localparam int unsigned OW = VVCTRL_OPCODE_WIDTH;
    localparam int unsigned WW = VVCTRL_WAITCYCLE_WIDTH;
    localparam int unsigned D  = VVCTRL_DRAIN_CYCLES;
    localparam int unsigned MW = IW - OW - WW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic en   = 1'b1;
    logic busy, done;

    vvctrl_issue_sequencer_if #(.INSTRUCTION_WIDTH(IW)) sif ();

    vvctrl_issue_sequencer dut (
        .clk            (clk),
        .rstn           (rstn),
        .dbg_clk_enable (en),
        .seq_if         (sif),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic r;
        logic b;
        logic d;
    } ctl_t;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Model: queue of expected not-ready cycles created by each accepted word.
    ctl_t          exp_q[$];
    logic          e_ready = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_ivalid = 1'b0;
    logic [IW-1:0] e_instr = '0;
    bit            m_inprog = 1'b0;
    bit            accepted = 1'b0;

    // Producer state.
    logic [IW:0]   prog_q[$];
    logic [IW:0]   cur_w = '0;
    bit            have_word = 1'b0;
    bit            dense = 1'b1;
    bit            rnd_en = 1'b0;
    logic          en_edge, rst_edge;
    int unsigned   nop_run = 0, last_gap = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic logic [IW-1:0] mk(input logic [OW-1:0] op, input logic [WW-1:0] n);
        logic [MW-1:0] mid;
        mid = MW'($urandom);
        return {op, mid, n};
    endfunction

    task automatic push(input logic [OW-1:0] op, input logic [WW-1:0] n, input logic last);
        logic [IW-1:0] w;
        w = mk(op, n);
        prog_q.push_back({last, w});
    endtask

    task automatic model_edge();
        logic [OW-1:0] op;
        int unsigned   u;
        ctl_t          c;
        accepted = 1'b0;
        if (!rstn) begin
            exp_q.delete();
            m_inprog = 1'b0;
            {e_ready, e_busy, e_done, e_ivalid} = 4'b0;
            e_instr = '0;
        end else if (!en) begin
            e_instr  = '0;
            e_ivalid = 1'b0;
        end else begin
            e_instr  = '0;
            e_ivalid = 1'b0;
            if (e_ready && sif.instrValid) begin
                accepted = 1'b1;
                op = sif.instrIn[IW-1 -: OW];
                u  = (op == VVCTRL_WAIT) ? int'(sif.instrIn[WW-1:0]) :
                     (op == VVCTRL_ACTLOOKUP) ? 1 : 0;
                if (op != VVCTRL_WAIT) begin
                    e_instr  = sif.instrIn;
                    e_ivalid = 1'b1;
                end
                m_inprog = 1'b1;
                if (sif.instrLast) begin
                    for (int i = 0; i < int'(u + D + 2); i++)
                        exp_q.push_back('{r: 1'b0, b: 1'b1, d: (i == int'(u + D + 1))});
                    m_inprog = 1'b0;
                end else begin
                    for (int i = 0; i < int'(u); i++)
                        exp_q.push_back('{r: 1'b0, b: 1'b1, d: 1'b0});
                end
            end
            if (exp_q.size() > 0) begin
                c = exp_q.pop_front();
                e_ready = c.r;
                e_busy  = c.b;
                e_done  = c.d;
            end else begin
                e_ready = 1'b1;
                e_busy  = m_inprog;
                e_done  = 1'b0;
            end
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        en_edge  = en;
        rst_edge = rstn;
        model_edge();
        #1;
        check_eq("issueInstr", 64'(sif.issueInstr), 64'(e_instr));
        check_eq("issueValid", 64'(sif.issueValid), 64'(e_ivalid));
        check_eq("instrReady", 64'(sif.instrReady), 64'(e_ready));
        check_eq("busy", 64'(busy), 64'(e_busy));
        check_eq("done", 64'(done), 64'(e_done));
        if (rst_edge && en_edge) begin
            if (sif.issueValid) begin
                last_gap = nop_run;
                nop_run  = 0;
            end else begin
                nop_run++;
            end
        end
        if (accepted) have_word = 1'b0;
        if (!have_word && prog_q.size() > 0 && (dense || $urandom_range(3) != 0)) begin
            cur_w     = prog_q.pop_front();
            have_word = 1'b1;
        end
        sif.instrValid = have_word;
        sif.instrIn    = have_word ? cur_w[IW-1:0] : IW'($urandom);
        sif.instrLast  = have_word ? cur_w[IW] : 1'($urandom);
        if (rnd_en) en = ($urandom_range(7) != 0);
    endtask

    task automatic run_prog();
        int unsigned k;
        k = 0;
        while ((prog_q.size() > 0 || have_word || m_inprog || exp_q.size() > 0) && k < 3000) begin
            run_cycle();
            k++;
        end
        check_eq("prog_timeout", 64'(k < 3000), 64'(1));
    endtask

    initial begin
        sif.instrIn    = '0;
        sif.instrValid = 1'b0;
        sif.instrLast  = 1'b0;
        repeat (2) run_cycle();
        rstn = 1'b1;
        run_cycle();

        // Back-to-back ordinary ops, then drain and done.
        push(VVCTRL_ADD_XY, 8'd1, 1'b0);
        push(VVCTRL_SUB_XY, 8'd2, 1'b0);
        push(VVCTRL_MULT_XY, 8'd3, 1'b1);
        run_prog();
        run_cycle();

        push(VVCTRL_ADD_XY, 8'd0, 1'b0);
        push(VVCTRL_WAIT, 8'd5, 1'b0);
        push(VVCTRL_ADD_XY, 8'd0, 1'b1);
        run_prog();
        check_eq("gap_wait5", 64'(last_gap), 64'd6);

        push(VVCTRL_ACTLOOKUP, 8'd9, 1'b0);
        push(VVCTRL_RELU, 8'd0, 1'b1);
        run_prog();
        check_eq("gap_actlookup", 64'(last_gap), 64'd1);

        push(VVCTRL_ADD_XY, 8'd0, 1'b0);
        push(VVCTRL_WAIT, 8'd255, 1'b0);
        push(VVCTRL_ADD_XY, 8'd0, 1'b1);
        run_prog();
        check_eq("gap_wait255", 64'(last_gap), 64'd256);

        push(VVCTRL_ADD_XY, 8'd0, 1'b0);
        push(VVCTRL_WAIT, 8'd0, 1'b0);
        push(VVCTRL_ADD_XY, 8'd0, 1'b1);
        run_prog();
        check_eq("gap_wait0", 64'(last_gap), 64'd1);

        // WAIT on the last word still drains.
        push(VVCTRL_WAIT, 8'd3, 1'b1);
        run_prog();

        // Reset in the middle of a WAIT.
        push(VVCTRL_ADD_XY, 8'd0, 1'b0);
        push(VVCTRL_WAIT, 8'd10, 1'b0);
        push(VVCTRL_ADD_XY, 8'd0, 1'b1);
        for (int i = 0; i < 100 && exp_q.size() != 3; i++) run_cycle();
        check_eq("rst_reach_wait", 64'(exp_q.size()), 64'd3);
        rstn = 1'b0;
        prog_q.delete();
        have_word = 1'b0;
        run_cycle();
        rstn = 1'b1;
        repeat (2) run_cycle();
        push(VVCTRL_ADD_XY, 8'd0, 1'b0);
        push(VVCTRL_SUB_XY, 8'd0, 1'b1);
        run_prog();

        // Step disable in the middle of a WAIT leaves the wait length unchanged.
        push(VVCTRL_ADD_XY, 8'd0, 1'b0);
        push(VVCTRL_WAIT, 8'd6, 1'b0);
        push(VVCTRL_ADD_XY, 8'd0, 1'b1);
        for (int i = 0; i < 100 && exp_q.size() != 4; i++) run_cycle();
        en = 1'b0;
        repeat (4) run_cycle();
        en = 1'b1;
        run_prog();
        check_eq("gap_wait6_frozen", 64'(last_gap), 64'd7);

        // Random programs, sparse producer, random step enable.
        dense  = 1'b0;
        rnd_en = 1'b1;
        for (int p = 0; p < 30; p++) begin
            int unsigned len;
            len = $urandom_range(5, 1);
            for (int i = 0; i < int'(len); i++) begin
                logic [OW-1:0] op;
                case ($urandom_range(5))
                    0: op = VVCTRL_ADD_XY;
                    1: op = VVCTRL_SUB_XY;
                    2: op = VVCTRL_MULT_XY;
                    3: op = VVCTRL_RELU;
                    4: op = VVCTRL_ACTLOOKUP;
                    default: op = VVCTRL_WAIT;
                endcase
                push(op, (op == VVCTRL_WAIT) ? WW'($urandom_range(4)) : WW'($urandom),
                     (i == int'(len) - 1));
            end
            run_prog();
            repeat ($urandom_range(2)) run_cycle();
        end
        rnd_en = 1'b0;
        en     = 1'b1;
        run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
